// File: rtl/ptr_bank_if.sv
// Bundle between ptr_bank_ctrl and its fetch stage, shared ALU and data memory.
// The controller takes the slave view; whoever drives instructions takes the master view.
interface ptr_bank_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 9
);
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    alu_result;
    logic [DATA_W-1:0]  mem_data;
    logic [PC_W-1:0]    alu_operand;
    logic               alu_op;
    logic [DATA_W-1:0]  mem_ptr;
    logic               searching;
    logic               depth_err;

    modport master (
        output instr_valid, instr, alu_result, mem_data,
        input  instr_ready, alu_operand, alu_op, mem_ptr, searching, depth_err
    );

    modport slave (
        input  instr_valid, instr, alu_result, mem_data,
        output instr_ready, alu_operand, alu_op, mem_ptr, searching, depth_err
    );
endinterface

// File: rtl/ptr_bank_ctrl.sv
// Pointer bank controller: NUM_PTR pointers (index 0 = working), ALU/memory steering, bracket search.
// Define PTR_LOAD_BYPASS_EN to complete LOADs on the transfer edge instead of via MEM_WAIT.
module ptr_bank_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PC_W    = 16,
    parameter int unsigned NUM_PTR = 4,
    parameter int unsigned DEPTH_W = 8
) (
    input logic       clk,
    input logic       rst_n,
    ptr_bank_if.slave bus
);
    localparam int unsigned SEL_W   = $clog2(NUM_PTR);
    localparam int unsigned INSTR_W = 5 + 2 * SEL_W;

    localparam logic [3:0] OpAlu    = 4'd0;
    localparam logic [3:0] OpLoad   = 4'd1;
    localparam logic [3:0] OpBrFwd  = 4'd2;
    localparam logic [3:0] OpBrBack = 4'd3;

    typedef enum logic [1:0] {StIdle, StMemWait, StSearch} state_e;

    state_e               state_q, state_d;
    logic                 dir_q, dir_d;  // 1 = backward search
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    ptr_q [NUM_PTR];
    logic [DATA_W-1:0]    ptr_d [NUM_PTR];
`ifndef PTR_LOAD_BYPASS_EN
    logic [SEL_W-1:0]     addr_q, addr_d;
`endif

    logic [3:0]           opcode;
    logic [SEL_W-1:0]     opsel, addrsel;
    logic                 ready, xfer, is_open, is_close;
    logic                 unused_alu_result;
    logic [DATA_W-1:0]    ptr_rd [2**SEL_W];

    assign opcode   = bus.instr[INSTR_W-1:INSTR_W-4];
    assign addrsel  = bus.instr[2*SEL_W:SEL_W+1];
    assign opsel    = bus.instr[SEL_W:1];
    assign xfer     = bus.instr_valid & ready;
    assign is_open  = dir_q ? (opcode == OpBrBack) : (opcode == OpBrFwd);
    assign is_close = dir_q ? (opcode == OpBrFwd) : (opcode == OpBrBack);
    assign unused_alu_result = ^bus.alu_result;

    // Selectors past NUM_PTR read as zero.
    for (genvar i = 0; i < 2**SEL_W; i++) begin : g_rd
        if (i < NUM_PTR) begin : g_real
            assign ptr_rd[i] = ptr_q[i];
        end else begin : g_pad
            assign ptr_rd[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dir_q   <= 1'b0;
            depth_q <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '{default: '0};
`ifndef PTR_LOAD_BYPASS_EN
            addr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
`ifndef PTR_LOAD_BYPASS_EN
            addr_q  <= addr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        depth_d = depth_q;
        err_d   = err_q;
        ptr_d   = ptr_q;
`ifndef PTR_LOAD_BYPASS_EN
        addr_d  = addr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    case (opcode)
                        OpAlu: begin
                            for (int i = 0; i < NUM_PTR; i++) begin
                                if (opsel == SEL_W'(i)) ptr_d[i] = bus.alu_result[DATA_W-1:0];
                            end
                        end
                        OpLoad: begin
`ifdef PTR_LOAD_BYPASS_EN
                            ptr_d[0] = bus.mem_data;
`else
                            state_d = StMemWait;
                            addr_d  = addrsel;
`endif
                        end
                        OpBrFwd: begin
                            if (ptr_q[0] == '0) begin
                                state_d = StSearch;
                                dir_d   = 1'b0;
                                depth_d = DEPTH_W'(1);
                            end
                        end
                        OpBrBack: begin
                            if (ptr_q[0] != '0) begin
                                state_d = StSearch;
                                dir_d   = 1'b1;
                                depth_d = DEPTH_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StMemWait: begin
                ptr_d[0] = bus.mem_data;
                state_d  = StIdle;
            end
            StSearch: begin
                if (xfer) begin
                    if (is_open) begin
                        // Saturate rather than wrap so a deep nest can still unwind.
                        if (depth_q == '1) err_d = 1'b1;
                        else depth_d = depth_q + DEPTH_W'(1);
                    end else if (is_close) begin
                        depth_d = depth_q - DEPTH_W'(1);
                        if (depth_q == DEPTH_W'(1)) state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
`ifdef PTR_LOAD_BYPASS_EN
        ready = 1'b1;
`else
        ready = (state_q != StMemWait);
`endif
        bus.instr_ready = ready;
        bus.searching   = (state_q == StSearch);
        bus.depth_err   = err_q;
        if (state_q == StSearch) begin
            bus.alu_operand = PC_W'(1);
            bus.alu_op      = dir_q;
        end else begin
            bus.alu_operand = PC_W'(ptr_rd[opsel]);
            bus.alu_op      = bus.instr[0];
        end
        bus.mem_ptr = ptr_rd[addrsel];
`ifndef PTR_LOAD_BYPASS_EN
        if (state_q == StMemWait) bus.mem_ptr = ptr_rd[addr_q];
`endif
    end
endmodule

// File: tb/tb_ptr_bank_ctrl.sv
// Directed bench for ptr_bank_ctrl (DEPTH_W=2): stimulus pushes expectations per cycle,
// a negedge monitor pops and compares them.
module tb_ptr_bank_ctrl;
    localparam logic [3:0] ALU = 4'd0, LD = 4'd1, BF = 4'd2, BB = 4'd3, NOP = 4'd7;

    typedef enum int {FRdy, FSrch, FErr, FMptr, FOpnd, FOp} field_e;
    typedef struct {
        int unsigned cyc;
        string       name;
        field_e      field;
        logic [15:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    chk_t        sb_q[$];

    ptr_bank_if #(.DATA_W(8), .PC_W(16), .INSTR_W(9)) bus ();

    ptr_bank_ctrl #(.DATA_W(8), .PC_W(16), .NUM_PTR(4), .DEPTH_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [8:0] mk(logic [3:0] opc, logic [1:0] asel, logic [1:0] osel,
                                      logic op);
        return {opc, asel, osel, op};
    endfunction

    task automatic step(logic rn, logic v, logic [8:0] ins, logic [15:0] ar, logic [7:0] md);
        @(posedge clk);
        #1;
        rst_n           = rn;
        bus.instr_valid = v;
        bus.instr       = ins;
        bus.alu_result  = ar;
        bus.mem_data    = md;
    endtask

    task automatic expect_out(string name, field_e f, logic [15:0] v);
        chk_t c;
        c.cyc   = cyc_cnt;
        c.name  = name;
        c.field = f;
        c.exp   = v;
        sb_q.push_back(c);
    endtask

    always @(negedge clk) begin
        chk_t        c;
        logic [15:0] act;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
            c = sb_q.pop_front();
            case (c.field)
                FRdy:    act = {15'b0, bus.instr_ready};
                FSrch:   act = {15'b0, bus.searching};
                FErr:    act = {15'b0, bus.depth_err};
                FMptr:   act = {8'b0, bus.mem_ptr};
                FOpnd:   act = bus.alu_operand;
                default: act = {15'b0, bus.alu_op};
            endcase
            n_checks++;
            if (c.cyc != cyc_cnt || act !== c.exp) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", c.name, c.cyc, act,
                         c.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        bus.alu_result = '0;
        bus.mem_data = '0;
        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);

        // Reset state, then build a search to interrupt with reset
        step(1, 1, mk(ALU, 2, 2, 0), 16'h0033, 0);
        expect_out("rst_rdy", FRdy, 1);
        expect_out("rst_srch", FSrch, 0);
        expect_out("rst_err", FErr, 0);
        expect_out("rst_opnd", FOpnd, 0);
        expect_out("rst_op", FOp, 0);
        expect_out("rst_mptr", FMptr, 0);
        step(1, 1, mk(BF, 2, 0, 0), 0, 0);
        expect_out("pre_p2", FMptr, 16'h33);
        step(0, 0, mk(NOP, 2, 0, 0), 0, 0);
        expect_out("pre_rst_srch", FSrch, 1);
        expect_out("pre_rst_opnd", FOpnd, 1);
        step(0, 0, mk(NOP, 2, 0, 0), 0, 0);
        expect_out("rst1_srch", FSrch, 0);
        step(1, 0, mk(NOP, 2, 0, 0), 0, 0);
        expect_out("rst2_srch", FSrch, 0);
        expect_out("rst2_rdy", FRdy, 1);
        expect_out("rst2_err", FErr, 0);
        for (int a = 0; a < 4; a++) begin
            step(1, 0, mk(NOP, 2'(a), 2'(a), 0), 0, 0);
            expect_out($sformatf("rst_ptr%0d", a), FMptr, 0);
        end

        // ALU write-back and wrap
        step(1, 1, mk(ALU, 1, 1, 0), 16'h0001, 0);
        expect_out("alu_opnd0", FOpnd, 0);
        expect_out("alu_op0", FOp, 0);
        step(1, 0, mk(NOP, 1, 1, 0), 0, 0);
        expect_out("alu_p1", FMptr, 16'h01);
        expect_out("alu_opnd1", FOpnd, 16'h0001);
        step(1, 1, mk(ALU, 1, 1, 0), 16'h0100, 0);
        step(1, 0, mk(NOP, 1, 1, 0), 0, 0);
        expect_out("alu_wrap", FMptr, 16'h00);
        step(1, 1, mk(ALU, 3, 3, 1), 16'hFFFF, 0);
        expect_out("alu_sub_op", FOp, 1);
        step(1, 0, mk(ALU, 3, 3, 0), 16'h0042, 0);
        expect_out("alu_p3", FMptr, 16'hFF);
        step(1, 0, mk(NOP, 3, 3, 0), 0, 0);
        expect_out("alu_novalid", FMptr, 16'hFF);

        // LOAD
        step(1, 1, mk(ALU, 2, 2, 0), 16'h0077, 0);
        step(1, 1, mk(LD, 2, 0, 0), 0, 8'h5A);
        expect_out("ld_rdy0", FRdy, 1);
        expect_out("ld_mptr", FMptr, 16'h77);
        step(1, 0, mk(NOP, 0, 0, 0), 0, 8'h5A);
`ifdef PTR_LOAD_BYPASS_EN
        expect_out("ld_byp_rdy", FRdy, 1);
        expect_out("ld_byp_work", FOpnd, 16'h005A);
`else
        expect_out("ld_wait_rdy", FRdy, 0);
        expect_out("ld_hold_mptr", FMptr, 16'h77);
`endif
        step(1, 0, mk(NOP, 0, 0, 0), 0, 8'h00);
        expect_out("ld_rdy_back", FRdy, 1);
        expect_out("ld_work", FOpnd, 16'h005A);
        expect_out("ld_work_mptr", FMptr, 16'h5A);

        // Forward search, working = 0
        step(1, 1, mk(ALU, 0, 0, 0), 16'h0000, 0);
        step(1, 1, mk(BB, 0, 0, 0), 0, 0);
        expect_out("s4_w0", FOpnd, 0);
        step(1, 1, mk(BF, 0, 0, 0), 0, 0);
        expect_out("s4_bb_noop", FSrch, 0);
        step(1, 1, mk(BF, 0, 0, 0), 0, 0);
        expect_out("s4_srch", FSrch, 1);
        expect_out("s4_opnd", FOpnd, 1);
        expect_out("s4_op", FOp, 0);
        expect_out("s4_rdy", FRdy, 1);
        step(1, 1, mk(NOP, 0, 0, 0), 0, 0);
        step(1, 1, mk(ALU, 1, 1, 0), 16'h0099, 0);
        expect_out("s4_mid", FSrch, 1);
        step(1, 1, mk(BB, 0, 0, 0), 0, 0);
        step(1, 1, mk(BB, 0, 0, 0), 0, 0);
        expect_out("s4_last", FSrch, 1);
        step(1, 0, mk(NOP, 1, 0, 0), 0, 0);
        expect_out("s4_done", FSrch, 0);
        expect_out("s4_p1", FMptr, 16'h00);
        expect_out("s4_w", FOpnd, 0);
        step(1, 0, mk(NOP, 2, 0, 0), 0, 0);
        expect_out("s4_p2", FMptr, 16'h77);
        step(1, 0, mk(NOP, 3, 0, 0), 0, 0);
        expect_out("s4_p3", FMptr, 16'hFF);

        // Backward search, working = 3, with an idle cycle mid-search
        step(1, 1, mk(ALU, 0, 0, 0), 16'h0003, 0);
        step(1, 1, mk(BF, 0, 0, 0), 0, 0);
        step(1, 1, mk(BB, 0, 0, 0), 0, 0);
        expect_out("s5_bf_noop", FSrch, 0);
        step(1, 1, mk(BB, 0, 0, 0), 0, 0);
        expect_out("s5_srch", FSrch, 1);
        expect_out("s5_op", FOp, 1);
        expect_out("s5_opnd", FOpnd, 1);
        step(1, 0, mk(BF, 0, 0, 0), 0, 0);
        step(1, 1, mk(BF, 0, 0, 0), 0, 0);
        expect_out("s5_hold", FSrch, 1);
        step(1, 1, mk(BF, 0, 0, 0), 0, 0);
        expect_out("s5_last", FSrch, 1);
        step(1, 0, mk(NOP, 0, 0, 0), 0, 0);
        expect_out("s5_done", FSrch, 0);
        expect_out("s5_w", FOpnd, 16'h0003);

        // Depth saturation at 3 with DEPTH_W = 2
        step(1, 1, mk(ALU, 0, 0, 0), 16'h0000, 0);
        step(1, 1, mk(BF, 0, 0, 0), 0, 0);
        step(1, 1, mk(BF, 0, 0, 0), 0, 0);
        step(1, 1, mk(BF, 0, 0, 0), 0, 0);
        expect_out("s6_noerr2", FErr, 0);
        step(1, 1, mk(BF, 0, 0, 0), 0, 0);
        expect_out("s6_noerr3", FErr, 0);
        step(1, 1, mk(BB, 0, 0, 0), 0, 0);
        expect_out("s6_err", FErr, 1);
        step(1, 1, mk(BB, 0, 0, 0), 0, 0);
        expect_out("s6_srch", FSrch, 1);
        step(1, 1, mk(BB, 0, 0, 0), 0, 0);
        expect_out("s6_srch2", FSrch, 1);
        step(1, 0, mk(NOP, 0, 0, 0), 0, 0);
        expect_out("s6_done", FSrch, 0);
        expect_out("s6_sticky", FErr, 1);
        step(0, 0, mk(NOP, 0, 0, 0), 0, 0);
        step(1, 0, mk(NOP, 0, 0, 0), 0, 0);
        expect_out("s6_rst_err", FErr, 0);
        expect_out("s6_rst_srch", FSrch, 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
